ram_burst_writer: RTL and testbench
===================================

Name: ram_burst_writer

Overview:
- Write-side counterpart to the team's single-address 16x16 synchronous memories: streams a burst of words into consecutive RAM locations.
- Accepts a start command (base address, length), takes words over a valid/ready stream and drives the RAM's clk/en/we/addr/data port.
- Sits between a data producer (DMA, loader, bench) and a single-port synchronous RAM.

Parameters:
- DATA_W, 16: memory word width.
- ADDR_W, 4: address width; depth = 2**ADDR_W (16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  ADDR_W  first write address; latched on accepted start.
- len  input  ADDR_W+1  words to write; latched on accepted start.
- s_valid  input  1  producer has a word.
- s_data  input  DATA_W  word to write.
- s_ready  output  1  block accepts a word this cycle.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data; used only when VERIFY_EN is defined.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  sticky error; cleared on next accepted start.

Behaviour:
- Reset (rst_n low, async): state IDLE; s_ready, mem_en, mem_we, busy, done, err = 0; mem_addr, mem_wdata = 0; internal counters cleared. Reset mid-burst aborts immediately. mem_we drops asynchronously. No further writes; no done pulse.
- States: IDLE, WRITE, DONE (plus VRD, VCMP with VERIFY_EN).
- IDLE: start high at edge T latches base_addr and len, clears err.
  - len==0: DONE after T; no writes.
  - len>16: clamp to 16, set err=1, go to WRITE.
  - otherwise: go to WRITE.
- start while busy: ignored; latched values unchanged.
- WRITE: s_ready = 1 (combinational, state==WRITE). Handshake = s_valid & s_ready at an edge.
- Handshake at edge k: for exactly the cycle after k, mem_en=1, mem_we=1, mem_addr=(base+count) mod 16, mem_wdata=s_data captured at k. Outputs are registered; latency is one cycle.
- No handshake: mem_en = mem_we = 0. Gaps in s_valid stall the burst indefinitely with no timeout.
- Address arithmetic is ADDR_W-bit and wraps: base 14 gives 14, 15, 0, 1, ...
- Last handshake (count==len-1) at edge k: state DONE after k (no VERIFY_EN). s_ready is 0 from that cycle on.
- DONE: done=1, busy=1 for one cycle, then IDLE. The last write and the done pulse occupy the same cycle.
- mem_en/mem_we are never asserted outside the cycles defined above.

Optional Feature:
- Macro: RAM_BURST_WRITER_VERIFY_EN.
- Defined:
  - WRITE keeps a running XOR of accepted words.
  - After the last handshake, one idle cycle lets the final write complete, then VRD.
  - VRD drives mem_en=1, mem_we=0 on the same len addresses, one per cycle, registered.
  - mem_rdata is sampled one cycle after each read and XOR-accumulated.
  - VCMP lasts one cycle: mismatch sets err=1, then DONE.
  - Burst-to-done time grows by len+2 cycles.
- Undefined: no VRD/VCMP states; mem_rdata ignored; err is set only by len clamp.

Test Plan:
- Reset: assert rst_n=0 mid-idle -> all outputs 0; release, hold s_valid=1 without start -> no mem_en, s_ready=0.
- Basic burst: start base=2 len=4, s_data 16'hA001..A004 continuous -> mem_we pulses at addr 2,3,4,5 with matching data. done pulses with the 4th write (non-verify); RAM then reads back A001..A004.
- Wrap and backpressure: base=14 len=4, s_valid toggling 1,0,1,0... -> writes at 14,15,0,1 only after valid cycles; mem_we low in gap cycles.
- Boundaries:
  - len=0 -> done one cycle after start, no mem_en.
  - len=20 -> exactly 16 writes at 0..15 from base 0, err=1.
  - start pulsed while busy -> ignored.
- Abort: rst_n low after 2 of 4 words -> mem_we low immediately; no done; next start works normally.
- VERIFY_EN: correct RAM -> err=0, done len+2 cycles later. RAM model corrupting addr 3 data bit 0 -> err=1 after done.

Source files
------------

// File: rtl/ram_burst_writer.sv
// Streams a burst of words from a valid/ready producer into consecutive addresses of a
// single-port synchronous RAM. Optional read-back check enabled by RAM_BURST_WRITER_VERIFY_EN.
module ram_burst_writer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_DONE, S_VWAIT, S_VRD, S_VCMP
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W:0]   len_r;
   logic [ADDR_W:0]   count;
   logic              err_r;
   logic              hs;
   logic              last_hs;
   logic              len_over;
   logic [ADDR_W:0]   len_clamped;

   assign hs          = s_valid & s_ready;
   assign last_hs     = hs && ((count + 1'b1) == len_r);
   assign len_over    = len > MAX_LEN;
   assign len_clamped = len_over ? MAX_LEN : len;

   // NOTE: state and datapath registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_WRITE;
`ifdef RAM_BURST_WRITER_VERIFY_EN
         S_WRITE: if (last_hs) state_nxt = S_VWAIT;
         S_VWAIT: state_nxt = S_VRD;
         S_VRD:   if (count == len_r) state_nxt = S_VCMP;
         S_VCMP:  state_nxt = S_DONE;
`else
         S_WRITE: if (last_hs) state_nxt = S_DONE;
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == S_WRITE);
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
      err     = err_r;
   end

`ifdef RAM_BURST_WRITER_VERIFY_EN
   logic [DATA_W-1:0] xor_wr;
   logic [DATA_W-1:0] xor_rd;
   logic              rd_vld;

   // rd_vld marks cycles where mem_rdata holds the result of the previous cycle's read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_wr <= '0;
         xor_rd <= '0;
         rd_vld <= 1'b0;
      end else begin
         rd_vld <= mem_en & ~mem_we;
         if (state == S_IDLE && start) begin
            xor_wr <= '0;
            xor_rd <= '0;
         end else if (state == S_WRITE && hs) begin
            xor_wr <= xor_wr ^ s_data;
         end else if (state == S_VRD && rd_vld) begin
            xor_rd <= xor_rd ^ mem_rdata;
         end
      end
   end
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_r    <= '0;
         len_r     <= '0;
         count     <= '0;
         err_r     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_r <= base_addr;
                  len_r  <= len_clamped;
                  count  <= '0;
                  err_r  <= len_over;
               end
            end
            S_WRITE: begin
               if (hs) begin
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= base_r + count[ADDR_W-1:0];
                  mem_wdata <= s_data;
                  count     <= count + 1'b1;
               end
            end
`ifdef RAM_BURST_WRITER_VERIFY_EN
            S_VWAIT: begin
               // The final write lands this cycle; queue the first read behind it.
               mem_en   <= 1'b1;
               mem_addr <= base_r;
               count    <= (ADDR_W+1)'(1);
            end
            S_VRD: begin
               if (count != len_r) begin
                  mem_en   <= 1'b1;
                  mem_addr <= base_r + count[ADDR_W-1:0];
                  count    <= count + 1'b1;
               end
            end
            S_VCMP: begin
               if ((xor_rd ^ mem_rdata) != xor_wr) err_r <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_writer.sv
// Directed bench for ram_burst_writer: per-cycle vector table plus hand sequences for
// clamping, reset abort and (with RAM_BURST_WRITER_VERIFY_EN) the read-back check.
module tb_ram_burst_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  base_addr;
   logic [4:0]  len;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] ram [16];
   logic        ram_clear;
   logic        corrupt;

   ram_burst_writer #(.DATA_W(16), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model; corrupt flips bit 0 of reads from address 3.
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 16; i++) ram[i] <= 16'hDEAD;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr] ^ {15'b0, (corrupt && mem_addr == 4'd3)};
      end
   end

   typedef struct {
      logic        start;
      logic [3:0]  base;
      logic [4:0]  len;
      logic        sv;
      logic [15:0] sd;
      logic        ready;
      logic        en;
      logic        we;
      logic [3:0]  addr;
      logic [15:0] wd;
      logic        busy;
      logic        done;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic [3:0] b, logic [4:0] l, logic sv,
                               logic [15:0] sd, logic rdy, logic en, logic we,
                               logic [3:0] a, logic [15:0] wd, logic bz, logic dn,
                               logic er);
      vec_t v;
      v.start = st; v.base = b;   v.len = l;   v.sv = sv;     v.sd = sd;
      v.ready = rdy; v.en = en;   v.we = we;   v.addr = a;    v.wd = wd;
      v.busy = bz;  v.done = dn;  v.err = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      start = v.start; base_addr = v.base; len = v.len; s_valid = v.sv; s_data = v.sd;
      @(negedge clk);
      check($sformatf("v%0d.s_ready", idx), s_ready, v.ready);
      check($sformatf("v%0d.mem_en", idx), mem_en, v.en);
      check($sformatf("v%0d.mem_we", idx), mem_we, v.we);
      check($sformatf("v%0d.busy", idx), busy, v.busy);
      check($sformatf("v%0d.done", idx), done, v.done);
      check($sformatf("v%0d.err", idx), err, v.err);
      if (v.we) begin
         check($sformatf("v%0d.mem_addr", idx), mem_addr, v.addr);
         check($sformatf("v%0d.mem_wdata", idx), mem_wdata, v.wd);
      end
      next_cycle();
   endtask

   initial begin
      int wr, dn, rd, done_row, exp_addr;

      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; s_valid = 1'b0; s_data = '0;
      corrupt = 1'b0; ram_clear = 1'b1;
      @(posedge clk);
      @(posedge clk);
      ram_clear = 1'b0;
      @(negedge clk);
      check("rst.busy", busy, 0);
      check("rst.mem_en", mem_en, 0);
      rst_n = 1'b1;
      next_cycle();

      // Idle with s_valid but no start: nothing may move.
      s_valid = 1'b1; s_data = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle.s_ready", s_ready, 0);
         check("idle.mem_en", mem_en, 0);
         next_cycle();
      end
      s_valid = 1'b0;

`ifndef RAM_BURST_WRITER_VERIFY_EN
      // Basic burst base 2 len 4.
      vecs.push_back(mk(1, 2, 4, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA001, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA002, 1, 1, 1, 2, 16'hA001, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA003, 1, 1, 1, 3, 16'hA002, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA004, 1, 1, 1, 4, 16'hA003, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA005, 0, 1, 1, 5, 16'hA004, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hA006, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      // Wrap from 14 with toggling valid; a start while busy must be ignored.
      vecs.push_back(mk(1, 14, 4, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hB001, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 14, 16'hB001, 1, 0, 0));
      vecs.push_back(mk(1, 7, 2, 1, 16'hB002, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 15, 16'hB002, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hB003, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'hB003, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hB004, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'hB004, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      // len 0: done right after start, no writes.
      vecs.push_back(mk(1, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hE001, 0, 0, 0, 0, 16'h0000, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

      foreach (vecs[i]) apply(vecs[i], i);

      check("ram[2]", ram[2], 16'hA001);
      check("ram[3]", ram[3], 16'hA002);
      check("ram[4]", ram[4], 16'hA003);
      check("ram[5]", ram[5], 16'hA004);
      check("ram[14]", ram[14], 16'hB001);
      check("ram[15]", ram[15], 16'hB002);
      check("ram[0]", ram[0], 16'hB003);
      check("ram[1]", ram[1], 16'hB004);
      check("ram[7]", ram[7], 16'hDEAD);
      check("ram[6]", ram[6], 16'hDEAD);
`endif

      // len 20 clamps to 16 writes at 0..15 and flags err.
      wr = 0; dn = 0; exp_addr = 0;
      for (int r = 0; r < 40; r++) begin
         start     = (r == 0);
         base_addr = 4'd0;
         len       = 5'd20;
         s_valid   = (r != 0);
         s_data    = 16'hC000 + 16'(r);
         @(negedge clk);
         if (r == 1) check("clamp.err_set", err, 1);
         if (mem_we) begin
            check($sformatf("clamp.addr%0d", wr), mem_addr, exp_addr);
            wr++;
            exp_addr++;
         end
         if (done) dn++;
         next_cycle();
      end
      start = 1'b0; s_valid = 1'b0;
      check("clamp.writes", wr, 16);
      check("clamp.done_pulses", dn, 1);
      check("clamp.err_sticky", err, 1);

      // Reset while idle clears every output, including held address/data and err.
      rst_n = 1'b0;
      #1;
      check("rst_idle.err", err, 0);
      check("rst_idle.mem_addr", mem_addr, 0);
      check("rst_idle.mem_wdata", mem_wdata, 0);
      check("rst_idle.busy", busy, 0);
      check("rst_idle.s_ready", s_ready, 0);
      check("rst_idle.mem_we", mem_we, 0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Abort after two of four words.
      start = 1'b1; base_addr = 4'd8; len = 5'd4; s_valid = 1'b0;
      next_cycle();
      start = 1'b0;
      s_valid = 1'b1; s_data = 16'hD001;
      next_cycle();
      s_data = 16'hD002;
      @(negedge clk);
      check("abort.first_write_addr", mem_addr, 8);
      next_cycle();
      s_valid = 1'b0;
      #1;
      check("abort.pre_we", mem_we, 1);
      check("abort.pre_addr", mem_addr, 9);
      rst_n = 1'b0;
      #1;
      check("abort.we_drop", mem_we, 0);
      check("abort.en_drop", mem_en, 0);
      check("abort.busy_drop", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wr = 0; dn = 0;
      s_valid = 1'b1; s_data = 16'hD003;
      for (int r = 0; r < 4; r++) begin
         next_cycle();
         @(negedge clk);
         if (mem_en) wr++;
         if (done) dn++;
      end
      next_cycle();
      s_valid = 1'b0;
      check("abort.no_writes", wr, 0);
      check("abort.no_done", dn, 0);

      // Restart after abort: single word to address 3.
      wr = 0; dn = 0;
      for (int r = 0; r < 30; r++) begin
         start = (r == 0); base_addr = 4'd3; len = 5'd1;
         s_valid = (r != 0); s_data = 16'hD00D;
         @(negedge clk);
         if (mem_we) begin
            check("restart.addr", mem_addr, 3);
            check("restart.data", mem_wdata, 16'hD00D);
            wr++;
         end
         if (done) dn++;
         next_cycle();
      end
      start = 1'b0; s_valid = 1'b0;
      check("restart.writes", wr, 1);
      check("restart.done_pulses", dn, 1);
      check("restart.ram3", ram[3], 16'hD00D);

`ifdef RAM_BURST_WRITER_VERIFY_EN
      // Correct RAM: done lands len+2 cycles later than the plain burst (row 5 -> row 11).
      for (int pass = 0; pass < 2; pass++) begin
         corrupt = (pass == 1);
         done_row = -1; rd = 0; wr = 0;
         for (int r = 0; r < 20; r++) begin
            start = (r == 0);
            base_addr = (pass == 0) ? 4'd2 : 4'd0;
            len = 5'd4;
            s_valid = (r >= 1 && r <= 4);
            s_data = 16'hF000 + 16'(r) + 16'(pass * 16);
            @(negedge clk);
            if (mem_en && !mem_we) rd++;
            if (mem_we) wr++;
            if (done && done_row < 0) done_row = r;
            next_cycle();
         end
         start = 1'b0; s_valid = 1'b0;
         check($sformatf("verify%0d.done_row", pass), done_row, 11);
         check($sformatf("verify%0d.reads", pass), rd, 4);
         check($sformatf("verify%0d.writes", pass), wr, 4);
         check($sformatf("verify%0d.err", pass), err, pass);
      end
      corrupt = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
